stitch_pattern_rx: RTL and testbench
====================================

Name: stitch_pattern_rx

Overview:
- Receiver for cross-stitch pattern bytes sent by an external host over a 4-bit nibble bus with a two-phase toggle handshake.
- Assembles each pair of nibbles into one byte and buffers the bytes in a small FIFO.
- The on-chip pattern renderer pops bytes from the FIFO and drives them toward uo_out.
- Sits between the TinyTapeout dedicated inputs (ui_in) and the display logic.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- AW, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- host_data  in  4  nibble from host; asynchronous to clk.
- host_stb  in  1  host strobe; each toggle (either edge) offers one nibble; asynchronous.
- host_ack  out  1  toggles once per accepted nibble.
- rd_en  in  1  pop request from renderer.
- rd_data  out  8  popped byte.
- rd_valid  out  1  one-cycle pulse; rd_data is valid while it is high.
- count  out  AW+1  current number of stored bytes.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky; a completed byte was dropped because the FIFO was full.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high. All registers update on the clk rising edge.
- Reset values:
  - host_ack = 0, rd_data = 0, rd_valid = 0, count = 0, full = 0, empty = 1, overflow = 0.
  - Nibble FSM = HI; read and write pointers = 0; strobe synchronizer flops = 0.
- Strobe synchronizer: host_stb passes through 2 flops (s1, s2) plus a history flop s3.
  - A toggle is detected when s2 != s3.
  - host_data is sampled in the same cycle the toggle is detected. No separate data synchronizer is used.
  - Host contract: hold host_data stable from before toggling host_stb until host_ack equals host_stb.
- Latency: a host_stb toggle sampled at edge N is detected and captured at edge N+2. host_ack is set to s2 at that same edge.
- Nibble FSM:
  - HI: on toggle, hi_reg <= host_data, go to LO.
  - LO: on toggle, form byte {hi_reg, host_data}, attempt a push, go to HI.
  - No other transitions.
- Push rules:
  - A push succeeds if !full, or if a pop occurs in the same cycle.
  - When full and no pop: the byte is discarded, overflow <= 1 (held until rst), and host_ack still toggles. The host is never stalled.
- Pop rules:
  - rd_en while !empty: the byte at the read pointer moves to rd_data at the next edge, rd_valid = 1 for exactly that cycle, read pointer advances.
  - rd_en while empty: ignored. rd_valid = 0, rd_data holds its last value. There is no bypass, even if a push completes in the same cycle.
- Simultaneous push and pop with the FIFO non-empty: both occur and count is unchanged.
- Pointers wrap modulo DEPTH.
- count, full and empty are registered and consistent with each other after every edge.
- Reset mid-operation:
  - A partial nibble is discarded and the FSM returns to HI.
  - FIFO contents are logically cleared; overflow is cleared.
  - host_ack returns to 0. The host must restart with host_stb = 0.

Test Plan:
- Basic byte: host_stb 0→1 with host_data=0xA, wait for ack=1, then 1→0 with 0x5, wait for ack=0 → count=1, empty=0. Then rd_en for 1 cycle → next cycle rd_valid=1, rd_data=0xA5, count=0, empty=1.
- Ack latency: host_stb toggles just before edge N → host_ack changes at edge N+2, never earlier or later; checked across 4 toggles.
- Fill and overflow: push bytes 0x00..0x0F → full=1, count=16. Push 0x77 → overflow=1, count=16, ack still toggles. Drain 16 pops → 0x00..0x0F in order, 0x77 never appears.
- Simultaneous push and pop at full: complete a byte 0x3C in the same cycle as rd_en → count stays 16, overflow stays 0, and 0x3C is read last after the remaining 15 bytes.
- Empty read and wrap: rd_en while empty → rd_valid=0. Then stream 40 bytes with interleaved pops so pointers wrap at least twice → output order matches input order exactly.
- Reset mid-byte: send only the high nibble 0xC, assert rst for 1 cycle → ack=0, count=0, FSM=HI. Then send 0x1,0x2 → popped byte is 0x12, not 0xC1.

Source files
------------

// File: rtl/stitch_pattern_rx_if.sv
// Host nibble bus and renderer pop port for stitch_pattern_rx.
// The master side is the host/renderer; the slave side is the receiver itself.
interface stitch_pattern_rx_if #(
    parameter int AW = 4
);
    logic [3:0]  host_data;
    logic        host_stb;
    logic        host_ack;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [AW:0] count;
    logic        full;
    logic        empty;
    logic        overflow;

    modport master (
        output host_data, host_stb, rd_en,
        input  host_ack, rd_data, rd_valid, count, full, empty, overflow
    );

    modport slave (
        input  host_data, host_stb, rd_en,
        output host_ack, rd_data, rd_valid, count, full, empty, overflow
    );
endinterface

// File: rtl/stitch_pattern_rx.sv
// Receives toggle-handshaked nibbles from an asynchronous host, pairs them into
// bytes and queues them in a small FIFO popped by the pattern renderer.
module stitch_pattern_rx #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    stitch_pattern_rx_if.slave bus
);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        ST_HI = 1'b0,
        ST_LO = 1'b1
    } nib_state_t;

    nib_state_t    state_q, state_d;
    logic          s1_q, s2_q, s3_q;
    logic          stb_toggle;
    logic [3:0]    hi_q, hi_d;
    logic          push_req;
    logic [7:0]    push_byte;
    logic          pop;
    logic          push_ok;
    logic          ack_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q;
    logic          overflow_q, overflow_d;
    logic [7:0]    rd_data_q;
    logic          rd_valid_q;
    logic [7:0]    mem [DEPTH];

    // host_data is only captured on a detected toggle; the host holds it
    // stable until it sees the ack, so it has long settled by then.
    assign stb_toggle = s2_q ^ s3_q;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        push_req  = 1'b0;
        push_byte = {hi_q, bus.host_data};
        if (stb_toggle) begin
            case (state_q)
                ST_HI: begin
                    hi_d    = bus.host_data;
                    state_d = ST_LO;
                end
                ST_LO: begin
                    push_req = 1'b1;
                    state_d  = ST_HI;
                end
                default: state_d = ST_HI;
            endcase
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    always_comb begin
        pop        = bus.rd_en && !empty_q;
        push_ok    = push_req && (!full_q || pop);
        overflow_d = overflow_q || (push_req && full_q && !pop);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            state_q    <= ST_HI;
            hi_q       <= 4'h0;
            ack_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            s1_q       <= bus.host_stb;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            state_q    <= state_d;
            hi_q       <= hi_d;
            if (stb_toggle) begin
                ack_q <= s2_q;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem[rd_ptr_q];
            end
            rd_valid_q <= pop;
            count_q    <= count_d;
            full_q     <= (count_d == CNT_FULL);
            empty_q    <= (count_d == '0);
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; clearing the pointers empties it logically.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_byte;
        end
    end

    assign bus.host_ack = ack_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.count    = count_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_stitch_pattern_rx.sv
// Directed and randomized bench for stitch_pattern_rx, checked every cycle
// against a queue-based model of the nibble link and FIFO.
module tb_stitch_pattern_rx;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stitch_pattern_rx_if #(.AW(AW)) bus ();

    stitch_pattern_rx #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int         commit;
        logic [3:0] nib;
    } ev_t;

    // Reference model state
    logic [7:0] byte_q[$];
    ev_t        pend[$];
    int         cyc;
    bit         m_lo;
    logic [3:0] m_hi;
    bit         m_ack;
    bit         m_valid;
    logic [7:0] m_rd_data;
    bit         m_ovf;

    int errors;
    int checks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        byte_q.delete();
        pend.delete();
        m_lo      = 1'b0;
        m_hi      = 4'h0;
        m_ack     = 1'b0;
        m_valid   = 1'b0;
        m_rd_data = 8'h00;
        m_ovf     = 1'b0;
    endtask

    // Advance one clock edge, update the model for that edge, then compare.
    task automatic step();
        ev_t        ev;
        logic [7:0] b;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            m_valid = bus.rd_en && (byte_q.size() > 0);
            if (m_valid) begin
                m_rd_data = byte_q.pop_front();
                $display("cycle %0d: pop byte 0x%02h", cyc, m_rd_data);
            end
            while (pend.size() > 0 && pend[0].commit == cyc) begin
                ev    = pend.pop_front();
                m_ack = ~m_ack;
                if (!m_lo) begin
                    m_hi = ev.nib;
                    m_lo = 1'b1;
                end else begin
                    m_lo = 1'b0;
                    b    = {m_hi, ev.nib};
                    if (byte_q.size() < DEPTH) begin
                        byte_q.push_back(b);
                        $display("cycle %0d: push byte 0x%02h", cyc, b);
                    end else begin
                        m_ovf = 1'b1;
                        $display("cycle %0d: drop byte 0x%02h (fifo full)", cyc, b);
                    end
                end
            end
        end
        #1;
        check("host_ack", 32'(bus.host_ack), 32'(m_ack));
        check("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
        check("rd_data",  32'(bus.rd_data),  32'(m_rd_data));
        check("count",    32'(bus.count),    32'(byte_q.size()));
        check("full",     32'(bus.full),     32'(byte_q.size() == DEPTH));
        check("empty",    32'(bus.empty),    32'(byte_q.size() == 0));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    // mode 0: no pops; 1: pop on the edge that commits this nibble; 2: random pops
    task automatic send_nibble(input logic [3:0] n, input int mode);
        bus.host_data = n;
        bus.host_stb  = ~bus.host_stb;
        pend.push_back('{commit: cyc + 3, nib: n});
        for (int i = 0; i < 3; i++) begin
            if (mode == 1)      bus.rd_en = (i == 2);
            else if (mode == 2) bus.rd_en = 1'($urandom_range(0, 1));
            else                bus.rd_en = 1'b0;
            step();
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int mode);
        send_nibble(b[7:4], (mode == 1) ? 0 : mode);
        send_nibble(b[3:0], mode);
    endtask

    task automatic pop_cycles(input int n);
        bus.rd_en = 1'b1;
        for (int i = 0; i < n; i++) step();
        bus.rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.host_stb = 1'b0;
        bus.rd_en    = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        cyc           = 0;
        rst           = 1'b1;
        bus.host_data = 4'h0;
        bus.host_stb  = 1'b0;
        bus.rd_en     = 1'b0;
        model_reset();
        #1;
        step();
        step();
        rst = 1'b0;
        step();
        check("reset_empty", 32'(bus.empty), 32'd1);

        // Basic byte
        send_byte(8'hA5, 0);
        check("basic_count", 32'(bus.count), 32'd1);
        pop_cycles(1);
        check("basic_data", 32'(bus.rd_data), 32'hA5);
        step();

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 0);
        check("fill_full", 32'(bus.full), 32'd1);
        send_byte(8'h77, 0);
        check("fill_overflow", 32'(bus.overflow), 32'd1);
        check("fill_ack", 32'(bus.host_ack), 32'(bus.host_stb));
        pop_cycles(DEPTH + 2);
        check("drain_empty", 32'(bus.empty), 32'd1);

        // Simultaneous push and pop at full
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h40 + i), 0);
        send_byte(8'h3C, 1);
        check("simul_count", 32'(bus.count), 32'(DEPTH));
        check("simul_ovf", 32'(bus.overflow), 32'd0);
        pop_cycles(DEPTH);
        check("simul_last", 32'(bus.rd_data), 32'h3C);
        step();

        // Empty read, then a randomized stream that wraps the pointers
        pop_cycles(2);
        for (int i = 0; i < 40; i++) send_byte(8'($urandom), 2);
        pop_cycles(DEPTH + 2);
        check("stream_empty", 32'(bus.empty), 32'd1);

        // Reset in the middle of a byte
        send_nibble(4'hC, 0);
        do_reset();
        check("rst_ack", 32'(bus.host_ack), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        send_byte(8'h12, 0);
        pop_cycles(1);
        check("rst_byte", 32'(bus.rd_data), 32'h12);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
